// File: rtl/golay_syn_dec.sv
// rtl/golay_syn_dec.sv - iterative hard-decision decoder for the extended Golay (24,12) code
//
// golay_pkg     : B_ROWS, the symmetric 12x12 parity matrix (B*B = I), and
//                 golay_matrix(i), the generator row [e_i | b_i].
// golay_syn_dec : clk, rst (sync, active-high)
//                 input side  : i_vld, i_rdy, i_code[0:23] = {wL, wR}
//                 output side : o_vld, o_rdy, o_data[0:11], o_err[1:0], o_fail
//                 Corrects up to 3 bit errors and flags 4-error words as
//                 uncorrectable. One word is in flight at a time.

package golay_pkg;

    localparam logic [0:11] B_ROWS [0:11] = '{
        12'b110111000101,
        12'b101110001011,
        12'b011100010111,
        12'b111000101101,
        12'b110001011011,
        12'b100010110111,
        12'b000101101111,
        12'b001011011101,
        12'b010110111001,
        12'b101101110001,
        12'b011011100011,
        12'b111111111110
    };

    // Systematic generator row: identity bit i on the left, parity row b_i on the right.
    function automatic logic [0:23] golay_matrix(input logic [3:0] i);
        logic [0:11] unit;
        unit = 12'h800 >> i;
        return {unit, B_ROWS[i]};
    endfunction

endpackage

module golay_syn_dec
    import golay_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vld,
    output logic        i_rdy,
    input  logic [0:23] i_code,
    output logic        o_vld,
    input  logic        o_rdy,
    output logic [0:11] o_data,
    output logic [1:0]  o_err,
    output logic        o_fail
);

    typedef enum logic [2:0] {IDLE, SYN, SRCH1, SYN2, SRCH2, DONE} state_t;

    function automatic logic [3:0] wt12(input logic [0:11] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 12; k++) c = c + {3'b000, v[k]};
        return c;
    endfunction

    function automatic logic [0:11] unit12(input logic [3:0] i);
        return 12'h800 >> i;
    endfunction

    state_t      state_q, state_d;
    logic [0:23] w_q, w_d;
    logic [0:11] s_q, s_d;
    logic [0:11] sb_q, sb_d;
    logic [3:0]  idx_q, idx_d;
    // Only the message half of the error pattern affects the output, so only it is kept.
    logic [0:11] e_q, e_d;
    logic [1:0]  err_q, err_d;
    logic        fail_q, fail_d;

    logic [0:11] b_row [0:11];
    logic [0:23] g_row;
    logic [0:11] s_calc, sb_calc, b_sel, t1, t2;
    logic [3:0]  ws, wsb, wt1, wt2;

    always_comb begin
        g_row = '0;
        for (int k = 0; k < 12; k++) begin
            g_row    = golay_matrix(4'(k));
            b_row[k] = g_row[12:23];
        end
    end

    // Syndromes: s = wL ^ wR*B, and sB = s*B (the syndrome seen from the parity half).
    always_comb begin
        s_calc  = w_q[0:11];
        sb_calc = '0;
        for (int k = 0; k < 12; k++) begin
            if (w_q[12 + k]) s_calc  = s_calc ^ b_row[k];
            if (s_q[k])      sb_calc = sb_calc ^ b_row[k];
        end
    end

    assign b_sel = b_row[idx_q];
    assign t1    = s_q ^ b_sel;
    assign t2    = sb_q ^ b_sel;
    assign ws    = wt12(s_calc);
    assign wsb   = wt12(sb_calc);
    assign wt1   = wt12(t1);
    assign wt2   = wt12(t2);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        s_d     = s_q;
        sb_d    = sb_q;
        idx_d   = idx_q;
        e_d     = e_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (i_vld) begin
                    w_d     = i_code;
                    state_d = SYN;
                end
            end
            SYN: begin
                s_d    = s_calc;
                fail_d = 1'b0;
                if (ws <= 4'd3) begin
                    e_d     = s_calc;
                    err_d   = ws[1:0];
                    state_d = DONE;
                end else begin
                    idx_d   = 4'd0;
                    state_d = SRCH1;
                end
            end
            SRCH1: begin
                if (wt1 <= 4'd2) begin
                    e_d     = t1;
                    err_d   = wt1[1:0] + 2'd1;
                    state_d = DONE;
                end else if (idx_q == 4'd11) begin
                    state_d = SYN2;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            SYN2: begin
                sb_d = sb_calc;
                if (wsb <= 4'd3) begin
                    e_d     = '0;
                    err_d   = wsb[1:0];
                    state_d = DONE;
                end else begin
                    idx_d   = 4'd0;
                    state_d = SRCH2;
                end
            end
            SRCH2: begin
                if (wt2 <= 4'd2) begin
                    e_d     = unit12(idx_q);
                    err_d   = wt2[1:0] + 2'd1;
                    state_d = DONE;
                end else if (idx_q == 4'd11) begin
                    e_d     = '0;
                    err_d   = 2'd0;
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: begin
                if (o_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            s_q     <= '0;
            sb_q    <= '0;
            idx_q   <= '0;
            e_q     <= '0;
            err_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            s_q     <= s_d;
            sb_q    <= sb_d;
            idx_q   <= idx_d;
            e_q     <= e_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign i_rdy  = (state_q == IDLE);
    assign o_vld  = (state_q == DONE);
    assign o_data = o_vld ? (w_q[0:11] ^ e_q) : '0;
    assign o_err  = o_vld ? err_q : 2'd0;
    assign o_fail = o_vld & fail_q;

endmodule

// File: doc/golay_syn_dec.md
# golay_syn_dec

Iterative hard-decision decoder for the extended Golay (24,12) code. It sits directly downstream of the Golay encoder: it takes 24-bit received words, corrects up to 3 bit errors, and flags 4-error patterns as uncorrectable. It uses the `golay_matrix` generator from `golay_pkg`, whose rows are systematic `[e_i | b_i]`: the 12×12 identity on bits 0..11 and the parity matrix B on bits 12..23, with B symmetric and B·B = I. Valid/ready handshakes are used on both sides, and one codeword is in flight at a time.

## Interface
Parameters:
- none; the code is fixed by `golay_pkg::golay_matrix`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_vld`  in  1  input codeword valid.
- `i_rdy`  out  1  decoder idle, can accept a codeword.
- `i_code`  in  [0:24-1]  received word w = {wL[0:11], wR[12:23]}.
- `o_vld`  out  1  result valid.
- `o_rdy`  in  1  consumer accepts result.
- `o_data`  out  [0:12-1]  corrected message, (w ^ e)[0:11].
- `o_err`  out  2  number of corrected bit errors, 0..3.
- `o_fail`  out  1  uncorrectable error (≥4 detected); `o_data` then equals wL uncorrected.

## Operation
- Reset:
  - state is IDLE; registers w, s, sB, index and e are cleared.
  - outputs after reset: `i_rdy`=1, `o_vld`=0, `o_data`=0, `o_err`=0, `o_fail`=0.
- FSM states: IDLE, SYN, SRCH1, SYN2, SRCH2, DONE.
- IDLE:
  - `i_rdy`=1.
  - On `i_vld`, register w and go to SYN.
- SYN:
  - s = wL ^ (wR·B), the XOR of rows b_i for each set bit wR[12+i]; register s.
  - If wt(s) ≤ 3: e = {s, 0}, go to DONE.
  - Otherwise: index=0, go to SRCH1.
- SRCH1 tests one index per cycle:
  - If wt(s ^ b_idx) ≤ 2: e = {s ^ b_idx, unit(idx)}, go to DONE.
  - Else if idx==11, go to SYN2.
  - Else idx++.
- SYN2:
  - sB = s·B; register it.
  - If wt(sB) ≤ 3: e = {0, sB}, go to DONE.
  - Otherwise: idx=0, go to SRCH2.
- SRCH2 tests one index per cycle:
  - If wt(sB ^ b_idx) ≤ 2: e = {unit(idx), sB ^ b_idx}, go to DONE.
  - Else if idx==11: fail=1, e=0, go to DONE.
  - Else idx++.
- DONE:
  - `o_vld`=1; `o_data`, `o_err` = wt(e) and `o_fail` are registered and stable.
  - On `o_rdy`, go to IDLE.
- Priority: the first match in the order SYN, SRCH1 (ascending idx), SYN2, SRCH2 (ascending idx) wins. For ≤3 errors the match is unique by the minimum distance of 8.
- `o_err` is 0 whenever `o_fail`=1.
- Weight functions are 12-bit popcounts compared against constants; no wider arithmetic is needed.

## Timing
- `i_rdy` is high only in IDLE. The accept cycle counts as cycle 0.
- `o_vld` first high in cycle:
  - 2: SYN hit.
  - 3+i: SRCH1 hit at i.
  - 15: SYN2 hit.
  - 16+j: SRCH2 hit at j.
  - 27: failure.
- Backpressure:
  - `o_vld` and the result hold indefinitely until `o_rdy`.
  - The handshake cycle returns to IDLE; the next accept is no earlier than the following cycle.
- `i_code` is sampled only in the accept cycle; later changes have no effect.
- `rst` at any state, mid-search or DONE, aborts the job.
  - The state is IDLE at the next edge.
  - The pending result is discarded and never presented.
- `rst` has priority over `i_vld` and `o_rdy` in the same cycle.

## Test plan
- d=12'h000, no errors: `o_vld` at cycle 2, `o_data`=0, `o_err`=0, `o_fail`=0. Repeat with `o_rdy` high continuously; `i_rdy` returns one cycle after the handshake.
- d=12'hA5C, encoded by the bench from `golay_matrix`, flip bits 0, 5, 11: `o_vld` at cycle 2, `o_data`=12'hA5C, `o_err`=3.
- d=12'hA5C, flip bits 2 and 13: SRCH1 hit at i=1, `o_vld` at cycle 4, `o_data`=12'hA5C, `o_err`=2.
- d=12'h3F0:
  - Flip bits 12, 18, 23: SYN2 hit, `o_vld` at cycle 15, `o_err`=3.
  - Flip bits 7, 14, 20: SRCH2 hit at j=7, `o_vld` at cycle 23, `o_data`=12'h3F0, `o_err`=3.
- d=12'hFFF, flip bits 0..3: `o_vld` at cycle 27, `o_fail`=1, `o_err`=0, `o_data`=12'h0FF (raw wL).
- Control sequences:
  - Hold `o_rdy` low 5 cycles: outputs stay stable and `i_vld` is ignored.
  - Assert `rst` at cycle 8 of a 4-error job: `o_vld` never rises, `i_rdy`=1 next cycle, and the following job decodes correctly.
